// File: rtl/gpio_event_capture_pkg.sv
// Shared types and sizing helpers for the GPIO event capture block.
package gpio_event_pkg;

  typedef enum logic {
    ARMING = 1'b0,
    ARMED  = 1'b1
  } arm_state_e;

  // Width of a counter that must hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned FILTER_CNT_W_DEFAULT = cnt_width(4);

endpackage

// File: rtl/gpio_event_capture_if.sv
// Pin-side and gpio_in/gpio_out-side signal bundle for gpio_event_capture.
interface gpio_event_capture_if #(
  parameter int unsigned WIDTH = 128
) ();

  // No handshake: every signal is a level, valid on every clock. The host
  // side drives pins/clear; the capture block drives the rest.
  logic [WIDTH-1:0] pins;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic             irq;
  logic             armed;

  modport master (
    output pins, clear,
    input  level, rise_evt, fall_evt, irq, armed
  );

  modport slave (
    input  pins, clear,
    output level, rise_evt, fall_evt, irq, armed
  );

endinterface

// File: rtl/gpio_event_capture_bit.sv
// One pin: synchronizer, glitch filter, level flop, clear edge detect and
// sticky rise/fall flags.
module gpio_event_bit
  import gpio_event_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arming_i,
  input  logic pin_i,
  input  logic clear_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   clear_q;
  logic                   sync;
  logic                   clr;
  logic                   rise_edge;
  logic                   fall_edge;

  always_comb begin
    sync      = sync_q[SYNC_STAGES-1];
    clr       = clear_i & ~clear_q;
    level_d   = level_q;
    cnt_d     = '0;
    rise_edge = 1'b0;
    fall_edge = 1'b0;
    if (arming_i) begin
      level_d = sync;
    end else if (sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = sync;
        rise_edge = sync;
        fall_edge = ~sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A new edge wins over a clear arriving in the same cycle.
    rise_d = (rise_q & ~clr) | rise_edge;
    fall_d = (fall_q & ~clr) | fall_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      clear_q <= clear_i;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_event_capture.sv
// Bank of WIDTH pin capture slices plus the post-reset arming sequencer and
// the registered interrupt summary.
module gpio_event_capture
  import gpio_event_pkg::*;
#(
  parameter int unsigned WIDTH         = 128,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_event_capture_if.slave  bus,
  output arm_state_e           dbg_state_o
);

  // Arming spans the synchronizer fill plus one filter window, so levels
  // are seeded from real pin state before any edge can be reported.
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + FILTER_CYCLES;
  localparam int unsigned ARM_W      = cnt_width(ARM_CYCLES);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  arm_state_e       state_q, state_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             irq_q;
  logic             arming;
  logic [WIDTH-1:0] level_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      ARMING: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = ARMED;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      ARMED:   state_d = ARMED;
      default: state_d = ARMING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARMING;
      arm_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      irq_q     <= (|rise_w) | (|fall_w);
    end
  end

  assign arming = (state_q == ARMING);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_event_bit #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .arming_i (arming),
      .pin_i    (bus.pins[i]),
      .clear_i  (bus.clear[i]),
      .level_o  (level_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i])
    );
  end

  assign bus.level    = level_w;
  assign bus.rise_evt = rise_w;
  assign bus.fall_evt = fall_w;
  assign bus.irq      = irq_q;
  assign bus.armed    = (state_q == ARMED);
  assign dbg_state_o  = state_q;

endmodule
